// File: rtl/serial_deserializer.sv
// MSB-first serial-to-parallel receiver with a single-entry valid/ready output buffer.
// Define SERIAL_DESER_PARITY_EN to expect an even-parity bit after each word.
module serial_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             start,
  output logic [WIDTH-1:0] p_out,
  output logic             p_valid,
  input  logic             p_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
`ifdef SERIAL_DESER_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1
`ifdef SERIAL_DESER_PARITY_EN
    ,
    PARITY = 2'd2
`endif
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_nextAcc;
  logic [WIDTH-1:0] w_shifted;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_nextCnt;
  logic [CW-1:0]    w_cntInc;
  logic             w_commit;
  logic [WIDTH-1:0] w_commitWord;
  logic             w_frameErr;
  logic             w_parityErr;

  logic [WIDTH-1:0] r_pOut;
  logic             r_pValid;
  logic             r_busy;
  logic             r_overrun;
  logic             r_frameErr;
  logic             r_parityErr;

  assign w_shifted = {r_acc[WIDTH-2:0], sin};
  assign w_cntInc  = r_cnt + CW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nextState;
      r_acc   <= w_nextAcc;
      r_cnt   <= w_nextCnt;
    end
  end

  // A start bit always begins a fresh word; outside IDLE it also abandons the partial one.
  always_comb begin
    w_nextState  = r_state;
    w_nextAcc    = r_acc;
    w_nextCnt    = r_cnt;
    w_commit     = 1'b0;
    w_commitWord = r_acc;
    w_frameErr   = 1'b0;
    w_parityErr  = 1'b0;
    if (sin_valid) begin
      if (start) begin
        w_frameErr  = (r_state != IDLE);
        w_nextAcc   = {{(WIDTH-1){1'b0}}, sin};
        w_nextCnt   = CW'(1);
        w_nextState = SHIFT;
      end else begin
        case (r_state)
          SHIFT: begin
            w_nextAcc = w_shifted;
            w_nextCnt = w_cntInc;
            if (w_cntInc == CW'(WIDTH)) begin
`ifdef SERIAL_DESER_PARITY_EN
              w_nextState = PARITY;
`else
              w_nextState  = IDLE;
              w_nextCnt    = '0;
              w_commit     = 1'b1;
              w_commitWord = w_shifted;
`endif
            end
          end
`ifdef SERIAL_DESER_PARITY_EN
          PARITY: begin
            w_nextState  = IDLE;
            w_nextCnt    = '0;
            w_commit     = 1'b1;
            w_commitWord = r_acc;
            w_parityErr  = ^{r_acc, sin};
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // A pop on the same edge frees the buffer, so a commit then is not an overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pOut      <= '0;
      r_pValid    <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
      r_frameErr  <= 1'b0;
      r_parityErr <= 1'b0;
    end else begin
      r_busy      <= (w_nextState != IDLE);
      r_overrun   <= 1'b0;
      r_frameErr  <= w_frameErr;
      r_parityErr <= w_parityErr;
      if (w_commit) begin
        if (!r_pValid || p_ready) begin
          r_pOut   <= w_commitWord;
          r_pValid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_pValid && p_ready) begin
        r_pValid <= 1'b0;
      end
    end
  end

  assign p_out     = r_pOut;
  assign p_valid   = r_pValid;
  assign busy      = r_busy;
  assign overrun   = r_overrun;
  assign frame_err = r_frameErr;
`ifdef SERIAL_DESER_PARITY_EN
  assign parity_err = r_parityErr;
`else
  logic w_unusedParity;
  assign w_unusedParity = r_parityErr;
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
// Self-checking bench for serial_deserializer: expected words go into a scoreboard
// queue when sent and are compared when the DUT presents them on p_out.
module tb_serial_deserializer;

  logic       clk;
  logic       reset;
  logic       sin;
  logic       sin_valid;
  logic       start;
  logic [7:0] p_out;
  logic       p_valid;
  logic       p_ready;
  logic       busy;
  logic       overrun;
  logic       frame_err;
`ifdef SERIAL_DESER_PARITY_EN
  logic       parity_err;
`endif

  int         testsRun = 0;
  int         failures = 0;
  logic [7:0] expQ[$];
  logic [7:0] expWord;

  serial_deserializer #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .sin       (sin),
    .sin_valid (sin_valid),
    .start     (start),
    .p_out     (p_out),
    .p_valid   (p_valid),
    .p_ready   (p_ready),
    .busy      (busy),
    .overrun   (overrun),
    .frame_err (frame_err)
`ifdef SERIAL_DESER_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  // Free-running clock; inputs change on falling edges, outputs sampled 1 unit after rising edges.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic sendBit(input logic b, input logic st, input logic rdy);
    @(negedge clk);
    sin       = b;
    sin_valid = 1'b1;
    start     = st;
    p_ready   = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    @(negedge clk);
    sin       = 1'($urandom);
    sin_valid = 1'b0;
    start     = 1'b0;
    p_ready   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic acceptWord();
    @(negedge clk);
    sin_valid = 1'b0;
    start     = 1'b0;
    p_ready   = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // rdyLast applies to the edge that completes the word (parity bit when enabled).
  task automatic sendWordPar(input logic [7:0] w, input logic par, input logic rdyLast, input logic rdyOthers);
    for (int i = 7; i >= 0; i--) begin
`ifdef SERIAL_DESER_PARITY_EN
      sendBit(w[i], i == 7, rdyOthers);
`else
      sendBit(w[i], i == 7, (i == 0) ? rdyLast : rdyOthers);
`endif
    end
`ifdef SERIAL_DESER_PARITY_EN
    sendBit(par, 1'b0, rdyLast);
`else
    if (par === 1'bx) $display("[TB] unexpected parity argument");
`endif
  endtask

  task automatic sendWord(input logic [7:0] w, input logic rdyLast, input logic rdyOthers);
    sendWordPar(w, ^w, rdyLast, rdyOthers);
  endtask

  task automatic test_reset();
    #2;
    testsRun++;
    if ({p_valid, busy, overrun, frame_err} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_flags: got %b expected 0000", {p_valid, busy, overrun, frame_err});
    end
    testsRun++;
    if (p_out !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_pout: got %h expected 00", p_out);
    end
`ifdef SERIAL_DESER_PARITY_EN
    testsRun++;
    if (parity_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_parity_err: got %b expected 0", parity_err);
    end
`endif
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] w;
    w = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      sendBit(w[i], i == 7, 1'b0);
      if (i == 1) begin
        testsRun++;
        if ({p_valid, busy} !== 2'b01) begin
          failures++;
          $display("[TB] FAIL basic_7th_bit: got valid,busy=%b expected 01", {p_valid, busy});
        end
      end
    end
`ifdef SERIAL_DESER_PARITY_EN
    testsRun++;
    if ({p_valid, busy} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL basic_before_parity: got valid,busy=%b expected 01", {p_valid, busy});
    end
    sendBit(^w, 1'b0, 1'b0);
`endif
    expQ.push_back(w);
    testsRun++;
    if ({p_valid, busy} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL basic_done: got valid,busy=%b expected 10", {p_valid, busy});
    end
    testsRun++;
    if (p_out !== expQ[0]) begin
      failures++;
      $display("[TB] FAIL basic_pout: got %h expected %h", p_out, expQ[0]);
    end
  endtask

  task automatic test_overrun();
    sendWord(8'h3C, 1'b0, 1'b0);
    testsRun++;
    if ({overrun, p_valid} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL overrun_pulse: got overrun,valid=%b expected 11", {overrun, p_valid});
    end
    testsRun++;
    if (p_out !== expQ[0]) begin
      failures++;
      $display("[TB] FAIL overrun_keep: got %h expected %h", p_out, expQ[0]);
    end
    idleCycle();
    testsRun++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("[TB] FAIL overrun_one_cycle: got %b expected 0", overrun);
    end
    expWord = expQ.pop_front();
    testsRun++;
    if (p_out !== expWord) begin
      failures++;
      $display("[TB] FAIL overrun_before_pop: got %h expected %h", p_out, expWord);
    end
    sendWord(8'hFF, 1'b1, 1'b0);
    expQ.push_back(8'hFF);
    testsRun++;
    if ({overrun, p_valid} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL pop_commit_flags: got overrun,valid=%b expected 01", {overrun, p_valid});
    end
    expWord = expQ.pop_front();
    testsRun++;
    if (p_out !== expWord) begin
      failures++;
      $display("[TB] FAIL pop_commit_pout: got %h expected %h", p_out, expWord);
    end
    acceptWord();
    testsRun++;
    if (p_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL pop_clears_valid: got %b expected 0", p_valid);
    end
  endtask

  task automatic test_frame_err();
    logic [7:0] w;
    w = 8'h6E;
    for (int i = 7; i >= 3; i--) sendBit(w[i], i == 7, 1'b0);
    w = 8'h81;
    for (int i = 7; i >= 0; i--) begin
      sendBit(w[i], i == 7, 1'b0);
      if (i == 7) begin
        testsRun++;
        if ({frame_err, busy, p_valid} !== 3'b110) begin
          failures++;
          $display("[TB] FAIL frame_err_pulse: got ferr,busy,valid=%b expected 110", {frame_err, busy, p_valid});
        end
      end
      if (i == 6) begin
        testsRun++;
        if (frame_err !== 1'b0) begin
          failures++;
          $display("[TB] FAIL frame_err_one_cycle: got %b expected 0", frame_err);
        end
      end
    end
`ifdef SERIAL_DESER_PARITY_EN
    sendBit(^w, 1'b0, 1'b0);
`endif
    expQ.push_back(w);
    expWord = expQ.pop_front();
    testsRun++;
    if ({p_valid, p_out} !== {1'b1, expWord}) begin
      failures++;
      $display("[TB] FAIL frame_restart_word: got valid=%b data=%h expected valid=1 data=%h", p_valid, p_out, expWord);
    end
    acceptWord();
  endtask

  task automatic test_gaps();
    logic [7:0] w;
    w = 8'h5A;
    for (int i = 7; i >= 0; i--) begin
      sendBit(w[i], i == 7, 1'b0);
      if (i > 0) begin
        repeat (3) idleCycle();
        if (i == 1) begin
          testsRun++;
          if ({p_valid, busy} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL gaps_before_last: got valid,busy=%b expected 01", {p_valid, busy});
          end
        end
      end
    end
`ifdef SERIAL_DESER_PARITY_EN
    repeat (3) idleCycle();
    sendBit(^w, 1'b0, 1'b0);
`endif
    expQ.push_back(w);
    expWord = expQ.pop_front();
    testsRun++;
    if ({p_valid, p_out} !== {1'b1, expWord}) begin
      failures++;
      $display("[TB] FAIL gaps_word: got valid=%b data=%h expected valid=1 data=%h", p_valid, p_out, expWord);
    end
    acceptWord();
  endtask

  task automatic test_async_reset();
    logic [7:0] w;
    sendWord(8'h96, 1'b0, 1'b0);
    w = 8'hC3;
    for (int i = 7; i >= 4; i--) sendBit(w[i], i == 7, 1'b0);
    testsRun++;
    if ({p_valid, busy} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL pre_reset_state: got valid,busy=%b expected 11", {p_valid, busy});
    end
    #2;
    reset = 1'b1;
    #1;
    testsRun++;
    if ({p_valid, busy, overrun, frame_err, p_out} !== 12'h000) begin
      failures++;
      $display("[TB] FAIL async_reset: got valid,busy,ovr,ferr=%b data=%h expected 0000 data=00", {p_valid, busy, overrun, frame_err}, p_out);
    end
    @(negedge clk);
    reset = 1'b0;
    sendWord(8'h0F, 1'b0, 1'b0);
    expQ.push_back(8'h0F);
    expWord = expQ.pop_front();
    testsRun++;
    if ({p_valid, frame_err, p_out} !== {2'b10, expWord}) begin
      failures++;
      $display("[TB] FAIL after_reset_word: got valid=%b ferr=%b data=%h expected valid=1 ferr=0 data=%h", p_valid, frame_err, p_out, expWord);
    end
    acceptWord();
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    for (int n = 0; n < 4; n++) begin
      w = 8'($urandom);
      expQ.push_back(w);
      sendWord(w, 1'b1, 1'b1);
      expWord = expQ.pop_front();
      testsRun++;
      if ({p_valid, overrun, frame_err, p_out} !== {3'b100, expWord}) begin
        failures++;
        $display("[TB] FAIL back_to_back_%0d: got valid,ovr,ferr=%b data=%h expected 100 data=%h", n, {p_valid, overrun, frame_err}, p_out, expWord);
      end
    end
    acceptWord();
    testsRun++;
    if (p_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL back_to_back_drain: got %b expected 0", p_valid);
    end
  endtask

`ifdef SERIAL_DESER_PARITY_EN
  task automatic test_parity();
    sendWordPar(8'h07, 1'b1, 1'b0, 1'b0);
    expQ.push_back(8'h07);
    expWord = expQ.pop_front();
    testsRun++;
    if ({parity_err, p_valid, p_out} !== {2'b01, expWord}) begin
      failures++;
      $display("[TB] FAIL parity_good: got perr,valid=%b data=%h expected 01 data=%h", {parity_err, p_valid}, p_out, expWord);
    end
    acceptWord();
    sendWordPar(8'h07, 1'b0, 1'b0, 1'b0);
    expQ.push_back(8'h07);
    expWord = expQ.pop_front();
    testsRun++;
    if ({parity_err, p_valid, p_out} !== {2'b11, expWord}) begin
      failures++;
      $display("[TB] FAIL parity_bad: got perr,valid=%b data=%h expected 11 data=%h", {parity_err, p_valid}, p_out, expWord);
    end
    idleCycle();
    testsRun++;
    if (parity_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL parity_one_cycle: got %b expected 0", parity_err);
    end
    acceptWord();
  endtask
`endif

  initial begin
    reset     = 1'b1;
    sin       = 1'b0;
    sin_valid = 1'b0;
    start     = 1'b0;
    p_ready   = 1'b0;
    test_reset();
    test_basic();
    test_overrun();
    test_frame_err();
    test_gaps();
    test_async_reset();
    test_back_to_back();
`ifdef SERIAL_DESER_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
